button_debouncer: RTL
=====================

// Module: button_debouncer
// PURPOSE
//  Conditions a raw push-button/header pin (e.g. the pin driving the 20-bit divider's RESET) into a clean level.
//  Synchronises the asynchronous pin into the internal-oscillator domain, rejects bounce shorter than STABLE_CYCLES.
//  Emits one-cycle edge pulses.
//  Sits directly upstream of the frequency divider / LED logic in the top level.
//  Runs on INTERNAL_OSC (2.08 MHz nominal).
// PARAMETERS
//  SYNC_STAGES    2      number of synchroniser flops (>=2)
//  STABLE_CYCLES  20800  consecutive stable cycles needed to accept a change (~10 ms @ 2.08 MHz); >=2
//  CNT_W          15     debounce counter width; must satisfy 2**CNT_W > STABLE_CYCLES
//  LONG_CYCLES    2080000 hold time for long-press (~1 s), used only with DEBOUNCE_LONG_PRESS_EN
//  LONG_W         21     long-press counter width; 2**LONG_W > LONG_CYCLES
// PORTS
//  CLOCK       in   1  single clock, internal oscillator; all logic posedge CLOCK
//  RESET       in   1  synchronous, active-high reset
//  BTN_RAW     in   1  asynchronous raw pin, active-high
//  BTN_LEVEL   out  1  debounced level
//  RISE_PULSE  out  1  one-cycle pulse when BTN_LEVEL goes 0->1
//  FALL_PULSE  out  1  one-cycle pulse when BTN_LEVEL goes 1->0
//  LONG_PULSE  out  1  one-cycle pulse on long press; constant 0 when feature compiled out
// BEHAVIOUR
//  Reset (sampled on CLOCK edge while RESET=1):
//   - sync flops=0, state=LOW_STABLE, counters=0
//   - BTN_LEVEL=0, RISE/FALL/LONG_PULSE=0
//  Synchroniser: sync = BTN_RAW delayed SYNC_STAGES cycles; FSM sees only sync.
//  FSM states and transitions:
//   - LOW_STABLE : sync=1 -> CHK_HIGH, cnt=1
//   - CHK_HIGH   : sync=0 -> LOW_STABLE, cnt=0 (bounce rejected, no pulse)
//                  sync=1 and cnt==STABLE_CYCLES-1 -> HIGH_STABLE
//                  otherwise cnt++
//   - HIGH_STABLE: sync=0 -> CHK_LOW, cnt=1
//   - CHK_LOW    : mirror of CHK_HIGH; commit -> LOW_STABLE
//  Outputs:
//   - BTN_LEVEL registered; updates in the cycle the FSM commits
//   - RISE/FALL_PULSE asserted in that same cycle, exactly 1 cycle wide
//   - Latency BTN_RAW edge -> BTN_LEVEL/pulse = SYNC_STAGES + STABLE_CYCLES cycles (+/-1 for async sampling)
//  Counter never wraps: it is held/cleared by the FSM, max value STABLE_CYCLES-1.
//  Boundary cases:
//   - Glitch of STABLE_CYCLES-1 cycles: rejected
//   - Glitch of exactly STABLE_CYCLES cycles: accepted
//   - Bounce restarts the count from 1 on the next change
//   - RESET mid-check: aborts the check; no pulse; level forced 0
//   - Pin held high through reset release: normal CHK_HIGH path; RISE_PULSE fires after the full latency
//   - RESET has priority over every event in the same cycle
// CONFIGURATION
//  DEBOUNCE_LONG_PRESS_EN defined:
//   - Long counter increments while in HIGH_STABLE; cleared on any other state
//   - LONG_PULSE fires once when the long counter reaches LONG_CYCLES-1
//   - Saturates; no repeat until the button is released and pressed again
//  Not defined:
//   - LONG_PULSE tied 0; no long counter logic synthesised
// STRUCTURE
//  Shared package fipsy_pkg:
//   - 2-bit state encoding localparams LOW_STABLE=0, CHK_HIGH=1, HIGH_STABLE=2, CHK_LOW=3
//   - OSC_HZ=2080000 constant, from which the parameter defaults derive
//  One sub-module: sync_ff (parameter STAGES; ports CLOCK, RESET, D, Q), reusable for the other header pins.
// TESTING (sim with STABLE_CYCLES=8, SYNC_STAGES=2, LONG_CYCLES=32)
//  1 Reset: RESET=1 for 3 cycles with BTN_RAW=1 -> all outputs 0 during reset
//    Release reset -> RISE_PULSE exactly once, at cycle 10 (+/-1), then BTN_LEVEL=1
//  2 Clean press: BTN_RAW 0->1 held 20 cycles -> BTN_LEVEL 1 after 10 (+/-1) cycles; one RISE_PULSE; no FALL_PULSE
//  3 Bounce: BTN_RAW high for 7 cycles, low for 1, high for 7, low -> BTN_LEVEL stays 0; no pulses
//  4 Release: from BTN_LEVEL=1, BTN_RAW->0 held 12 cycles -> FALL_PULSE exactly once at 10 (+/-1) cycles; BTN_LEVEL=0
//  5 Mid-check reset: press, assert RESET at check count 5 for 1 cycle -> no RISE_PULSE at old time
//    Fresh RISE_PULSE 10 (+/-1) cycles after RESET deassert
//  6 Long press (macro on): hold 60 cycles -> exactly one LONG_PULSE, 32 cycles after BTN_LEVEL rose
//    Macro off: LONG_PULSE always 0

Source files
------------

// File: rtl/fipsy_pkg.sv
// Shared constants for the Fipsy header-pin logic: oscillator rate, debounce
// defaults and the 2-bit debouncer state encoding.
package fipsy_pkg;

  localparam int unsigned OSC_HZ = 2080000;

  // ~10 ms debounce window and ~1 s long-press hold at the nominal oscillator.
  localparam int unsigned DEF_STABLE_CYCLES = OSC_HZ / 100;
  localparam int unsigned DEF_LONG_CYCLES   = OSC_HZ;

  localparam logic [1:0] LOW_STABLE  = 2'd0;
  localparam logic [1:0] CHK_HIGH    = 2'd1;
  localparam logic [1:0] HIGH_STABLE = 2'd2;
  localparam logic [1:0] CHK_LOW     = 2'd3;

  // Bits needed to hold the value n itself.
  function automatic int unsigned width_for(input int unsigned n);
    return $clog2(n + 1);
  endfunction

  localparam int unsigned DEF_CNT_W  = width_for(DEF_STABLE_CYCLES);
  localparam int unsigned DEF_LONG_W = width_for(DEF_LONG_CYCLES);

endpackage

// File: rtl/sync_ff.sv
// Multi-flop synchroniser for an asynchronous single-bit input; flops clear
// on the synchronous reset.
module sync_ff #(
  parameter int unsigned STAGES = 2
) (
  input  logic CLOCK,
  input  logic RESET,
  input  logic D,
  output logic Q
);

  logic [STAGES-1:0] chain_q;

  always_ff @(posedge CLOCK) begin
    if (RESET) chain_q <= '0;
    else       chain_q <= {chain_q[STAGES-2:0], D};
  end

  assign Q = chain_q[STAGES-1];

endmodule

// File: rtl/button_debouncer.sv
// Push-button conditioner: synchroniser, stable-count debounce FSM, edge pulses.
// Optional long-press pulse is built only when DEBOUNCE_LONG_PRESS_EN is defined.
module button_debouncer
  import fipsy_pkg::*;
#(
  parameter int unsigned SYNC_STAGES   = 2,
  parameter int unsigned STABLE_CYCLES = DEF_STABLE_CYCLES,
  parameter int unsigned CNT_W         = DEF_CNT_W,
  parameter int unsigned LONG_CYCLES   = DEF_LONG_CYCLES,
  parameter int unsigned LONG_W        = DEF_LONG_W
) (
  input  logic CLOCK,
  input  logic RESET,
  input  logic BTN_RAW,
  output logic BTN_LEVEL,
  output logic RISE_PULSE,
  output logic FALL_PULSE,
  output logic LONG_PULSE
);

  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(STABLE_CYCLES - 1);

  logic             sync;
  logic [1:0]       state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             level_q, level_d;
  logic             rise_q, rise_d;
  logic             fall_q, fall_d;

  sync_ff #(.STAGES(SYNC_STAGES)) u_sync (
    .CLOCK (CLOCK),
    .RESET (RESET),
    .D     (BTN_RAW),
    .Q     (sync)
  );

  // The counter only runs in the CHK states, so it never exceeds CNT_LAST.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    level_d = level_q;
    rise_d  = 1'b0;
    fall_d  = 1'b0;
    case (state_q)
      LOW_STABLE: begin
        if (sync) begin
          state_d = CHK_HIGH;
          cnt_d   = CNT_ONE;
        end
      end
      CHK_HIGH: begin
        if (!sync) begin
          state_d = LOW_STABLE;
          cnt_d   = '0;
        end else if (cnt_q == CNT_LAST) begin
          state_d = HIGH_STABLE;
          cnt_d   = '0;
          level_d = 1'b1;
          rise_d  = 1'b1;
        end else begin
          cnt_d = cnt_q + CNT_ONE;
        end
      end
      HIGH_STABLE: begin
        if (!sync) begin
          state_d = CHK_LOW;
          cnt_d   = CNT_ONE;
        end
      end
      CHK_LOW: begin
        if (sync) begin
          state_d = HIGH_STABLE;
          cnt_d   = '0;
        end else if (cnt_q == CNT_LAST) begin
          state_d = LOW_STABLE;
          cnt_d   = '0;
          level_d = 1'b0;
          fall_d  = 1'b1;
        end else begin
          cnt_d = cnt_q + CNT_ONE;
        end
      end
      default: begin
        state_d = LOW_STABLE;
        cnt_d   = '0;
      end
    endcase
  end

  always_ff @(posedge CLOCK) begin
    if (RESET) begin
      state_q <= LOW_STABLE;
      cnt_q   <= '0;
      level_q <= 1'b0;
      rise_q  <= 1'b0;
      fall_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      level_q <= level_d;
      rise_q  <= rise_d;
      fall_q  <= fall_d;
    end
  end

  assign BTN_LEVEL  = level_q;
  assign RISE_PULSE = rise_q;
  assign FALL_PULSE = fall_q;

`ifdef DEBOUNCE_LONG_PRESS_EN
  localparam logic [LONG_W-1:0] LONG_ONE  = LONG_W'(1);
  localparam logic [LONG_W-1:0] LONG_LAST = LONG_W'(LONG_CYCLES - 1);
  localparam logic [LONG_W-1:0] LONG_SAT  = LONG_W'(LONG_CYCLES);

  logic [LONG_W-1:0] long_cnt_q, long_cnt_d;
  logic              long_q, long_d;

  // Saturating one past LONG_LAST guarantees a single pulse per press.
  always_comb begin
    long_cnt_d = '0;
    long_d     = 1'b0;
    if (state_q == HIGH_STABLE) begin
      long_d     = (long_cnt_q == LONG_LAST);
      long_cnt_d = (long_cnt_q == LONG_SAT) ? long_cnt_q : long_cnt_q + LONG_ONE;
    end
  end

  always_ff @(posedge CLOCK) begin
    if (RESET) begin
      long_cnt_q <= '0;
      long_q     <= 1'b0;
    end else begin
      long_cnt_q <= long_cnt_d;
      long_q     <= long_d;
    end
  end

  assign LONG_PULSE = long_q;
`else
  assign LONG_PULSE = 1'b0;
`endif

endmodule
